// File: rtl/pwm_drive.sv
// H-bridge PWM transmitter with double-buffered duty/direction and dead periods on reversal.
// Optional low-side brake on zero duty: define PWM_DRIVE_BRAKE_EN.
module pwm_drive #(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned DEAD_PERIODS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] duty,
    input  logic       dir,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       period_start,
    output logic       busy_dead
);

    localparam int unsigned PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DeadW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [PsW-1:0]   PsLast   = PsW'(PRESCALE - 1);
    localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDead
    } state_e;

    state_e           state_q, state_d;
    logic [PsW-1:0]   ps_q, ps_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       duty_sh_q, duty_sh_d;
    logic             dir_sh_q, dir_sh_d;
    logic [DeadW-1:0] dead_q, dead_d;

    logic pwm_a_d, pwm_b_d, period_start_d, busy_dead_d;
    logic step, boundary, active, reversal, brake, first_clk;

    always_comb begin
        step      = (ps_q == PsLast);
        boundary  = step && (cnt_q == 8'hff);
        first_clk = (ps_q == '0) && (cnt_q == 8'h00);
        active    = (cnt_q < duty_sh_q);
        // A zero-duty request never needs a dead gap: neither leg will be driven.
        reversal  = (dir != dir_sh_q) && (duty != 8'h00);
`ifdef PWM_DRIVE_BRAKE_EN
        brake     = (duty_sh_q == 8'h00);
`else
        brake     = 1'b0;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ps_d      = ps_q;
        cnt_d     = cnt_q;
        duty_sh_d = duty_sh_q;
        dir_sh_d  = dir_sh_q;
        dead_d    = dead_q;

        if (!en) begin
            state_d = StIdle;
            ps_d    = '0;
            cnt_d   = 8'h00;
            dead_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StRun;
                    ps_d      = '0;
                    cnt_d     = 8'h00;
                    dead_d    = '0;
                    duty_sh_d = duty;
                    dir_sh_d  = dir;
                end
                StRun, StDead: begin
                    ps_d  = step ? '0 : ps_q + PsW'(1);
                    cnt_d = step ? cnt_q + 8'd1 : cnt_q;
                    if (boundary) begin
                        if (state_q == StRun) begin
                            // Shadows load now; on reversal they are held through DEAD.
                            duty_sh_d = duty;
                            dir_sh_d  = dir;
                            dead_d    = '0;
                            if (reversal) begin
                                state_d = StDead;
                            end
                        end else if (dead_q == DeadLast) begin
                            state_d = StRun;
                            dead_d  = '0;
                        end else begin
                            dead_d = dead_q + DeadW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output decode, registered below
    always_comb begin
        pwm_a_d        = 1'b0;
        pwm_b_d        = 1'b0;
        period_start_d = 1'b0;
        busy_dead_d    = 1'b0;

        if (en) begin
            unique case (state_q)
                StRun: begin
                    if (brake) begin
                        pwm_a_d = 1'b1;
                        pwm_b_d = 1'b1;
                    end else begin
                        pwm_a_d = active & dir_sh_q;
                        pwm_b_d = active & ~dir_sh_q;
                    end
                    period_start_d = first_clk;
                end
                StDead: begin
                    busy_dead_d    = 1'b1;
                    period_start_d = first_clk;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ps_q         <= '0;
            cnt_q        <= 8'h00;
            duty_sh_q    <= 8'h00;
            dir_sh_q     <= 1'b0;
            dead_q       <= '0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            period_start <= 1'b0;
            busy_dead    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ps_q         <= ps_d;
            cnt_q        <= cnt_d;
            duty_sh_q    <= duty_sh_d;
            dir_sh_q     <= dir_sh_d;
            dead_q       <= dead_d;
            pwm_a        <= pwm_a_d;
            pwm_b        <= pwm_b_d;
            period_start <= period_start_d;
            busy_dead    <= busy_dead_d;
        end
    end

endmodule

// File: doc/pwm_drive.md
# pwm_drive

H-bridge PWM transmitter that turns the 8-bit control effort from the control-law stage into motor drive waveforms. It takes the effort magnitude and error sign from `r = k*|g-m|/256`. Duty and direction are double-buffered and switch only at period boundaries. A direction reversal inserts dead periods so both bridge legs are never driven in opposite senses back-to-back.

## Interface
Parameters:
- PRESCALE, 4: clocks per PWM count step (≥1); period = 256*PRESCALE clocks.
- DEAD_PERIODS, 1: full PWM periods with both legs low on direction reversal (≥1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- en  input  1  drive enable.
- duty  input  8  effort magnitude from control stage; high time = duty/256 of period.
- dir  input  1  1 = forward (g > m), 0 = reverse.
- pwm_a  output  1  forward leg drive, registered.
- pwm_b  output  1  reverse leg drive, registered.
- period_start  output  1  one-clock pulse on the first clock of each RUN/DEAD period.
- busy_dead  output  1  high while in DEAD.

## Operation
- State: IDLE, RUN, DEAD. Internal: prescaler `ps` (0..PRESCALE-1), 8-bit count `cnt`, shadow `duty_sh`, `dir_sh`, dead counter.
- Reset values:
  - Outputs: all outputs 0.
  - State and counters: state IDLE, ps=0, cnt=0, duty_sh=0, dir_sh=0, dead counter 0.
- Count step:
  - `ps` increments each clock in RUN/DEAD.
  - At PRESCALE-1, `ps` wraps to 0 and `cnt` increments.
  - `cnt` wraps 255→0; that wrap is the period boundary.
- IDLE:
  - ps/cnt held 0; outputs 0.
  - en=1 → load duty_sh←duty, dir_sh←dir; next state RUN at cnt=0.
- RUN:
  - pwm_a = (cnt < duty_sh) & dir_sh.
  - pwm_b = (cnt < duty_sh) & ~dir_sh.
- Period boundary in RUN:
  - If dir ≠ dir_sh and duty ≠ 0: enter DEAD and load duty_sh←duty, dir_sh←dir (applied after DEAD).
  - Otherwise: stay in RUN and load duty_sh←duty, dir_sh←dir.
- DEAD:
  - Both legs 0; busy_dead=1.
  - Counts DEAD_PERIODS full periods, then returns to RUN using the held shadows.
  - Input changes during DEAD are ignored until the next boundary in RUN.
- Duty 0 → both legs low for the whole period; dir changes with duty=0 load silently, no DEAD.
- Duty 255 → high 255 of 256 counts; 100% is unreachable.
- en=0 in any state → IDLE next clock; outputs 0 that clock; counters cleared.
- reset mid-period → all registers to reset values next clock, regardless of en.
- reset and en both high → reset wins.

## Timing
- Outputs are registered: pwm_*/period_start/busy_dead reflect state decoded the previous clock.
- en rising at clock t → state RUN at t+1; period_start and first pwm high (if duty_sh>0) at t+2.
- In RUN the active leg is high for exactly duty_sh*PRESCALE consecutive clocks starting with the period_start clock, then low for the rest of the period.
- period_start spacing = 256*PRESCALE clocks, including across DEAD.
- Duty/dir input change latency: takes effect at the next period boundary, i.e. up to 256*PRESCALE clocks; inputs are sampled on the clock where ps=PRESCALE-1 and cnt=255.
- Reversal: old direction's last period completes → DEAD_PERIODS*256*PRESCALE clocks both low → new direction.

## Configuration
- PWM_DRIVE_BRAKE_EN defined:
  - In RUN with duty_sh=0, pwm_a=pwm_b=1 (low-side brake) for the whole period.
  - DEAD and IDLE remain both-low.
- Undefined: duty_sh=0 gives both legs low (coast).
- Test plan covers both builds.

## Test plan
- PRESCALE=1, duty=64, dir=1, en 0→1 → pwm_a high 64 clocks / low 192 per 256-clock period; pwm_b constant 0; period_start every 256 clocks.
- Duty change 64→200 mid-period → current period keeps 64 high clocks; next period shows 200.
- Direction reversal, PRESCALE=2, DEAD_PERIODS=1, duty=128, dir 1→0 → pwm_a finishes the period; busy_dead for 512 clocks with both legs 0; then pwm_b high 256 clocks per 512.
- Extremes:
  - duty=0 → both 0 (brake build: both 1).
  - duty=255, PRESCALE=1 → high 255 and low 1 per period.
  - duty=0 with dir toggle → no DEAD.
- Mid-period interrupts:
  - en dropped at cnt=100 → outputs 0 next clock, state IDLE.
  - reset asserted at cnt=100 with en=1 → IDLE and all outputs 0 next clock.
  - Re-enable → period_start 2 clocks later.
